// File: rtl/ad5302_ldac_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : ad5302_ldac_ctrl
// Description : Multi-channel LDAC strobe generator for a bank of AD5302 DACs.
//               Decodes addressed 32-bit command words from the UART register
//               path and drives per-channel active-low LDAC lines with single
//               or free-running periodic pulses of programmable width/period.
// Revision    : 1.0 - initial release
//==============================================================================
module ad5302_ldac_ctrl #(
    parameter int          NUM_CH     = 4,
    parameter logic [15:0] ADDRESS    = 16'hDAC0,
    parameter logic [12:0] DEF_PW     = 13'd11,
    parameter logic [12:0] DEF_PERIOD = 13'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       uart_reg,
    input  logic              uart_ready,
    output logic [NUM_CH-1:0] ldac_n,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [1:0] OP_SINGLE   = 2'b00;
    localparam logic [1:0] OP_PERIODIC = 2'b01;
    localparam logic [1:0] OP_STOP     = 2'b10;
    localparam logic [1:0] OP_CONFIG   = 2'b11;

    state_t              state_q, state_d;
    logic [12:0]         cnt_q, cnt_d;
    logic [12:0]         pw_q, pw_d;          // programmed pulse width
    logic [12:0]         per_q, per_d;        // programmed period
    logic [12:0]         cur_pw_q, cur_pw_d;  // width of the pulse in flight
    logic [12:0]         gap_q, gap_d;        // gap length of the run in flight
    logic [NUM_CH-1:0]   mask_q, mask_d;      // mask driving the current pulse
    logic [NUM_CH-1:0]   pend_q, pend_d;      // mask for subsequent pulses
    logic                periodic_q, periodic_d;
    logic                err_d;
    logic [NUM_CH-1:0]   ldac_n_q;
    logic                busy_q;
    logic                cmd_err_q;

    logic                w_hit;
    logic [1:0]          w_op;
    logic [NUM_CH-1:0]   w_cmask;
    logic [12:0]         w_val;
    logic [12:0]         w_gap_cfg;
    logic [12:0]         w_gap_cur;

    assign w_hit   = uart_ready && (uart_reg[31:16] == ADDRESS);
    assign w_op    = uart_reg[15:14];
    assign w_cmask = uart_reg[NUM_CH-1:0];
    assign w_val   = uart_reg[12:0];

    // Gap lengths; a CONFIG issued mid-run may break PER > PW, in which case
    // the gap is clamped to one cycle instead of wrapping the 13-bit counter.
    assign w_gap_cfg = (per_q > pw_q)     ? (per_q - pw_q)     : 13'd1;
    assign w_gap_cur = (per_q > cur_pw_q) ? (per_q - cur_pw_q) : 13'd1;

    // Next-state, counter and command decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 13'd1;
        pw_d       = pw_q;
        per_d      = per_q;
        cur_pw_d   = cur_pw_q;
        gap_d      = gap_q;
        mask_d     = mask_q;
        pend_d     = pend_q;
        periodic_d = periodic_q;
        err_d      = 1'b0;

        // Timed progression of the active run.
        case (state_q)
            S_IDLE: begin
                cnt_d = 13'd0;
            end
            S_PULSE: begin
                if (cnt_q == cur_pw_q - 13'd1) begin
                    cnt_d   = 13'd0;
                    state_d = periodic_q ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q == gap_q - 13'd1) begin
                    cnt_d    = 13'd0;
                    state_d  = S_PULSE;
                    mask_d   = pend_q;
                    cur_pw_d = pw_q;
                    gap_d    = w_gap_cfg;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 13'd0;
            end
        endcase

        // Accepted commands override the timed progression.
        if (w_hit) begin
            case (w_op)
                OP_SINGLE: begin
                    if ((w_cmask == '0) || (state_q != S_IDLE)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_PULSE;
                        cnt_d      = 13'd0;
                        mask_d     = w_cmask;
                        pend_d     = w_cmask;
                        periodic_d = 1'b0;
                        cur_pw_d   = pw_q;
                        gap_d      = w_gap_cfg;
                    end
                end
                OP_PERIODIC: begin
                    if ((w_cmask == '0) || (per_q <= pw_q)) begin
                        err_d = 1'b1;
                    end else if ((state_q == S_IDLE) || periodic_q) begin
                        // Fresh start or restart: straight into a new pulse.
                        state_d    = S_PULSE;
                        cnt_d      = 13'd0;
                        mask_d     = w_cmask;
                        pend_d     = w_cmask;
                        periodic_d = 1'b1;
                        cur_pw_d   = pw_q;
                        gap_d      = w_gap_cfg;
                    end else begin
                        // Single pulse in flight: finish it on its own mask,
                        // then continue periodically on the new one.
                        periodic_d = 1'b1;
                        pend_d     = w_cmask;
                        gap_d      = w_gap_cur;
                        if (state_d == S_IDLE) begin
                            state_d = S_GAP;
                            cnt_d   = 13'd0;
                        end
                    end
                end
                OP_STOP: begin
                    state_d    = S_IDLE;
                    cnt_d      = 13'd0;
                    periodic_d = 1'b0;
                end
                OP_CONFIG: begin
                    if (w_val == 13'd0) begin
                        err_d = 1'b1;
                    end else if (uart_reg[13]) begin
                        per_d = w_val;
                    end else begin
                        pw_d = w_val;
                    end
                end
                default: begin
                    err_d = 1'b0;
                end
            endcase
        end
    end

    // State, configuration and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 13'd0;
            pw_q       <= DEF_PW;
            per_q      <= DEF_PERIOD;
            cur_pw_q   <= DEF_PW;
            gap_q      <= 13'd1;
            mask_q     <= '0;
            pend_q     <= '0;
            periodic_q <= 1'b0;
            ldac_n_q   <= '1;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pw_q       <= pw_d;
            per_q      <= per_d;
            cur_pw_q   <= cur_pw_d;
            gap_q      <= gap_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            periodic_q <= periodic_d;
            ldac_n_q   <= (state_q == S_PULSE) ? ~mask_q : '1;
            busy_q     <= (state_q != S_IDLE);
            cmd_err_q  <= err_d;
        end
    end

    assign ldac_n  = ldac_n_q;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule
`default_nettype wire
